asi_wmem: RTL and testbench

//  Consumes the asi_w user-side write-beat stream (m_w*) and turns it into single-port SRAM

---
 rtl/asi_wmem.sv | 223 ++++++++++++++++++++++
 tb/tb_asi_wmem.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/asi_wmem.sv
// asi_wmem: turns the asi_w write-beat stream into single-port SRAM writes.
// Each beat is decoded against the SRAM address window, and its byte lanes are
// masked by size and alignment. The beat is also tracked against its burst
// length. All results appear one cycle after the beat.

package asi_pkg;
    localparam int AXI_IW     = 4;
    localparam int AXI_AW     = 32;
    localparam int AXI_LW     = 8;
    localparam int AXI_SW     = 3;
    localparam int AXI_BURSTW = 2;
    localparam int AXI_DW     = 64;
    localparam int AXI_WSTRBW = AXI_DW / 8;
    localparam int SLV_BYTEW  = AXI_WSTRBW;
endpackage

module asi_wmem
    import asi_pkg::*;
#(
    parameter int                MEM_AW    = 10,
    parameter logic [AXI_AW-1:0] BASE_ADDR = {AXI_AW{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [AXI_IW-1:0]     s_wid,
    input  logic [AXI_LW-1:0]     s_wlen,
    input  logic [AXI_SW-1:0]     s_wsize,
    input  logic [AXI_AW-1:0]     s_waddr,
    input  logic [AXI_DW-1:0]     s_wdata,
    input  logic [AXI_WSTRBW-1:0] s_wstrb,
    input  logic                  s_wlast,
    input  logic                  s_wvalid,
    input  logic                  clr_stat,
    output logic                  mem_ce,
    output logic                  mem_we,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [AXI_DW-1:0]     mem_wdata,
    output logic [AXI_WSTRBW-1:0] mem_wbe,
    output logic                  err_len,
    output logic                  err_range,
    output logic                  err_size,
    output logic [AXI_IW-1:0]     err_id,
    output logic [31:0]           stat_beats,
    output logic [15:0]           stat_bursts
);

    localparam int LB = $clog2(AXI_WSTRBW);
    // Window size in bytes, one bit wider than the address so the top edge is representable.
    localparam logic [AXI_AW:0] WIN_BYTES = {{AXI_AW{1'b0}}, 1'b1} << (MEM_AW + LB);

    typedef enum logic [0:0] {ST_HEAD = 1'b0, ST_BODY = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [AXI_LW-1:0]       len_q, len_d;
    logic [AXI_IW-1:0]       id_q, id_d;
    logic [AXI_LW-1:0]       beat_cc_q, beat_cc_d;

    logic                    mem_ce_q, mem_ce_d;
    logic [MEM_AW-1:0]       mem_addr_q, mem_addr_d;
    logic [AXI_DW-1:0]       mem_wdata_q, mem_wdata_d;
    logic [AXI_WSTRBW-1:0]   mem_wbe_q, mem_wbe_d;
    logic                    err_len_q, err_len_d;
    logic                    err_range_q, err_range_d;
    logic                    err_size_q, err_size_d;
    logic [AXI_IW-1:0]       err_id_q, err_id_d;
    logic [31:0]             stat_beats_q, stat_beats_d;
    logic [15:0]             stat_bursts_q, stat_bursts_d;

    logic [AXI_AW:0]         off_s;
    logic                    in_range_s;
    logic                    size_err_s;
    logic [LB:0]             nbytes_s;
    logic [LB-1:0]           amask_s;
    logic [LB:0]             lo_s;
    logic [LB:0]             hi_s;
    logic [AXI_WSTRBW-1:0]   lane_mask_s;
    logic                    final_s;
    logic [AXI_IW-1:0]       cur_id_s;

    // Address window decode, size check and byte-lane mask for the incoming beat.
    always_comb begin
        off_s      = {1'b0, s_waddr} - {1'b0, BASE_ADDR};
        in_range_s = (s_waddr >= BASE_ADDR) && (off_s < WIN_BYTES);
        size_err_s = (s_wsize > AXI_SW'(LB));
        // When the size is oversized the mask is meaningless, but that beat is dropped anyway.
        nbytes_s   = {{LB{1'b0}}, 1'b1} << s_wsize;
        amask_s    = nbytes_s[LB-1:0] - LB'(1);
        lo_s       = {1'b0, s_waddr[LB-1:0]};
        hi_s       = {1'b0, s_waddr[LB-1:0] & ~amask_s} + nbytes_s - (LB+1)'(1);
        lane_mask_s = {AXI_WSTRBW{1'b0}};
        for (int i = 0; i < AXI_WSTRBW; i++) begin
            lane_mask_s[i] = ((LB+1)'(i) >= lo_s) && ((LB+1)'(i) <= hi_s);
        end
    end

    // Burst tracker: the HEAD beat latches the id and length; BODY beats count up to the length.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        id_d      = id_q;
        beat_cc_d = beat_cc_q;
        final_s   = 1'b0;
        cur_id_s  = id_q;
        if (s_wvalid) begin
            case (state_q)
                ST_HEAD: begin
                    id_d     = s_wid;
                    len_d    = s_wlen;
                    cur_id_s = s_wid;
                    if (s_wlen == {AXI_LW{1'b0}}) begin
                        final_s   = 1'b1;
                        beat_cc_d = {AXI_LW{1'b0}};
                        state_d   = ST_HEAD;
                    end else begin
                        beat_cc_d = {{(AXI_LW-1){1'b0}}, 1'b1};
                        state_d   = ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (beat_cc_q == len_q) begin
                        final_s   = 1'b1;
                        beat_cc_d = {AXI_LW{1'b0}};
                        state_d   = ST_HEAD;
                    end else begin
                        beat_cc_d = beat_cc_q + {{(AXI_LW-1){1'b0}}, 1'b1};
                        state_d   = ST_BODY;
                    end
                end
                default: begin
                    state_d   = ST_HEAD;
                    beat_cc_d = {AXI_LW{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Next values of the registered SRAM port, error pulses and statistics.
    always_comb begin
        mem_ce_d    = s_wvalid && in_range_s && !size_err_s;
        err_size_d  = s_wvalid && size_err_s;
        err_range_d = s_wvalid && !size_err_s && !in_range_s;
        err_len_d   = s_wvalid && (s_wlast != final_s);
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wbe_d   = mem_wbe_q;
        if (mem_ce_d) begin
            mem_addr_d  = off_s[LB +: MEM_AW];
            mem_wdata_d = s_wdata;
            mem_wbe_d   = s_wstrb & lane_mask_s;
        end else begin
            mem_addr_d  = mem_addr_q;
        end
        if (err_size_d || err_range_d || err_len_d) begin
            err_id_d = cur_id_s;
        end else begin
            err_id_d = err_id_q;
        end
        if (clr_stat) begin
            stat_beats_d = 32'd0;
        end else if (mem_ce_d && (stat_beats_q != 32'hFFFF_FFFF)) begin
            stat_beats_d = stat_beats_q + 32'd1;
        end else begin
            stat_beats_d = stat_beats_q;
        end
        if (clr_stat) begin
            stat_bursts_d = 16'd0;
        end else if (s_wvalid && final_s && (stat_bursts_q != 16'hFFFF)) begin
            stat_bursts_d = stat_bursts_q + 16'd1;
        end else begin
            stat_bursts_d = stat_bursts_q;
        end
    end

    // State and output registers; reset discards any burst in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_HEAD;
            len_q         <= {AXI_LW{1'b0}};
            id_q          <= {AXI_IW{1'b0}};
            beat_cc_q     <= {AXI_LW{1'b0}};
            mem_ce_q      <= 1'b0;
            mem_addr_q    <= {MEM_AW{1'b0}};
            mem_wdata_q   <= {AXI_DW{1'b0}};
            mem_wbe_q     <= {AXI_WSTRBW{1'b0}};
            err_len_q     <= 1'b0;
            err_range_q   <= 1'b0;
            err_size_q    <= 1'b0;
            err_id_q      <= {AXI_IW{1'b0}};
            stat_beats_q  <= 32'd0;
            stat_bursts_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            id_q          <= id_d;
            beat_cc_q     <= beat_cc_d;
            mem_ce_q      <= mem_ce_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wbe_q     <= mem_wbe_d;
            err_len_q     <= err_len_d;
            err_range_q   <= err_range_d;
            err_size_q    <= err_size_d;
            err_id_q      <= err_id_d;
            stat_beats_q  <= stat_beats_d;
            stat_bursts_q <= stat_bursts_d;
        end
    end

    assign mem_ce      = mem_ce_q;
    assign mem_we      = mem_ce_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wbe     = mem_wbe_q;
    assign err_len     = err_len_q;
    assign err_range   = err_range_q;
    assign err_size    = err_size_q;
    assign err_id      = err_id_q;
    assign stat_beats  = stat_beats_q;
    assign stat_bursts = stat_bursts_q;

endmodule

// File: tb/tb_asi_wmem.sv
// Bench for asi_wmem: directed scenarios followed by random bursts, checked
// against a burst-level reference model.

module tb_asi_wmem;
    import asi_pkg::*;

    localparam int                MEM_AW = 10;
    localparam logic [AXI_AW-1:0] BASE   = 32'h0000_1000;
    localparam longint            WIN    = 64'd8192;

    logic                  clk;
    logic                  rst_n;
    logic [AXI_IW-1:0]     s_wid;
    logic [AXI_LW-1:0]     s_wlen;
    logic [AXI_SW-1:0]     s_wsize;
    logic [AXI_AW-1:0]     s_waddr;
    logic [AXI_DW-1:0]     s_wdata;
    logic [AXI_WSTRBW-1:0] s_wstrb;
    logic                  s_wlast;
    logic                  s_wvalid;
    logic                  clr_stat;
    logic                  mem_ce;
    logic                  mem_we;
    logic [MEM_AW-1:0]     mem_addr;
    logic [AXI_DW-1:0]     mem_wdata;
    logic [AXI_WSTRBW-1:0] mem_wbe;
    logic                  err_len;
    logic                  err_range;
    logic                  err_size;
    logic [AXI_IW-1:0]     err_id;
    logic [31:0]           stat_beats;
    logic [15:0]           stat_bursts;

    asi_wmem #(.MEM_AW(MEM_AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_wid(s_wid), .s_wlen(s_wlen), .s_wsize(s_wsize), .s_waddr(s_waddr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .clr_stat(clr_stat),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wbe(mem_wbe), .err_len(err_len), .err_range(err_range), .err_size(err_size),
        .err_id(err_id), .stat_beats(stat_beats), .stat_bursts(stat_bursts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state (burst position, last written word, counters).
    bit          m_busy;
    int          m_len;
    int          m_idx;
    int          m_id;
    int          m_err_id;
    logic [31:0] m_beats;
    logic [15:0] m_bursts;
    int          m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_wbe;
    bit          e_ce, e_len, e_range, e_size;

    // Stimulus-side burst generator state.
    bit          g_busy;
    int          g_len, g_idx, g_id, g_size;
    longint      g_start;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_mask(input longint addr, input int size);
        logic [7:0] m;
        int bytes;
        int lo;
        int hi;
        m = 8'h00;
        if (size <= 3) begin
            bytes = 1 << size;
            lo    = int'(addr % 8);
            hi    = int'(((addr / bytes) * bytes) % 8) + bytes - 1;
            for (int i = 0; i < 8; i++) m[i] = (i >= lo) && (i <= hi);
        end
        return m;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_ce"}, 64'(mem_ce), 64'(e_ce));
        chk({tag, "_we"}, 64'(mem_we), 64'(e_ce));
        chk({tag, "_err_len"}, 64'(err_len), 64'(e_len));
        chk({tag, "_err_range"}, 64'(err_range), 64'(e_range));
        chk({tag, "_err_size"}, 64'(err_size), 64'(e_size));
        chk({tag, "_err_id"}, 64'(err_id), 64'(m_err_id));
        chk({tag, "_beats"}, 64'(stat_beats), 64'(m_beats));
        chk({tag, "_bursts"}, 64'(stat_bursts), 64'(m_bursts));
        chk({tag, "_addr"}, 64'(mem_addr), 64'(m_addr));
        chk({tag, "_wdata"}, mem_wdata, m_wdata);
        chk({tag, "_wbe"}, 64'(mem_wbe), 64'(m_wbe));
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_len = 0; m_idx = 0; m_id = 0; m_err_id = 0;
        m_beats = 32'd0; m_bursts = 16'd0; m_addr = 0; m_wdata = 64'd0; m_wbe = 8'd0;
        e_ce = 1'b0; e_len = 1'b0; e_range = 1'b0; e_size = 1'b0;
        g_busy = 1'b0;
    endtask

    // One clock cycle: drive a beat (or idle), advance the model, check one cycle later.
    task automatic step(input string tag, input bit v, input int id, input int len, input int size,
                        input longint addr, input logic [63:0] data, input logic [7:0] strb,
                        input bit last, input bit clr);
        bit fin;
        bit bad_size;
        bit inr;
        s_wvalid = v; s_wid = AXI_IW'(id); s_wlen = AXI_LW'(len); s_wsize = AXI_SW'(size);
        s_waddr = AXI_AW'(addr); s_wdata = data; s_wstrb = strb; s_wlast = last; clr_stat = clr;
        e_ce = 1'b0; e_len = 1'b0; e_range = 1'b0; e_size = 1'b0;
        if (v) begin
            if (!m_busy) begin m_len = len; m_idx = 0; m_id = id; end
            fin      = (m_idx == m_len);
            bad_size = (size > 3);
            inr      = (addr >= longint'(BASE)) && (addr - longint'(BASE) < WIN);
            e_size   = bad_size;
            e_range  = !bad_size && !inr;
            e_ce     = !bad_size && inr;
            e_len    = (last != fin);
            if (e_ce) begin
                m_addr  = int'((addr - longint'(BASE)) / 8);
                m_wdata = data;
                m_wbe   = strb & ref_mask(addr, size);
            end
            if (e_size || e_range || e_len) m_err_id = m_id;
            if (clr) m_beats = 32'd0;
            else if (e_ce && m_beats != 32'hFFFF_FFFF) m_beats = m_beats + 32'd1;
            if (clr) m_bursts = 16'd0;
            else if (fin && m_bursts != 16'hFFFF) m_bursts = m_bursts + 16'd1;
            if (fin) m_busy = 1'b0;
            else begin m_busy = 1'b1; m_idx++; end
        end else if (clr) begin
            m_beats = 32'd0; m_bursts = 16'd0;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 0, 0, 0, 64'd0, 64'd0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        s_wvalid = 1'b0; clr_stat = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        s_wid = '0; s_wlen = '0; s_wsize = '0; s_waddr = '0; s_wdata = '0;
        s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; clr_stat = 1'b0; rst_n = 1'b1;
        model_reset();
        #2;
        do_reset("reset");
        idle("idle0");

        // 1: aligned INCR burst of four 64-bit beats.
        for (int i = 0; i < 4; i++)
            step("t1", 1'b1, 3, 3, 3, longint'(BASE) + 16 + 8 * i, {$urandom, $urandom},
                 8'hFF, i == 3, 1'b0);
        chk("t1_last_addr", 64'(mem_addr), 64'd5);
        chk("t1_beats_const", 64'(stat_beats), 64'd4);
        chk("t1_bursts_const", 64'(stat_bursts), 64'd1);
        idle("t1_idle");
        chk("t1_hold_addr", 64'(mem_addr), 64'd5);

        // 2: narrow unaligned single beat.
        step("t2", 1'b1, 5, 0, 1, longint'(BASE) + 5, 64'h1122334455667788, 8'hFF, 1'b1, 1'b0);
        chk("t2_wbe_const", 64'(mem_wbe), 64'h20);
        chk("t2_addr_const", 64'(mem_addr), 64'd0);

        // 3: early WLAST on a three-beat burst; the burst still ends on length.
        step("t3a", 1'b1, 9, 2, 3, longint'(BASE) + 64, 64'd1, 8'hFF, 1'b0, 1'b0);
        step("t3b", 1'b1, 9, 2, 3, longint'(BASE) + 72, 64'd2, 8'hFF, 1'b1, 1'b0);
        chk("t3b_err_len_const", 64'(err_len), 64'd1);
        chk("t3b_err_id_const", 64'(err_id), 64'd9);
        step("t3c", 1'b1, 9, 2, 3, longint'(BASE) + 80, 64'd3, 8'hFF, 1'b0, 1'b0);
        chk("t3c_err_len_const", 64'(err_len), 64'd1);
        step("t3d", 1'b1, 2, 0, 3, longint'(BASE) + 88, 64'd4, 8'hFF, 1'b1, 1'b0);

        // 4: window edges, plus a beat just below the base.
        step("t4a", 1'b1, 4, 0, 3, longint'(BASE) + 64'h1FF8, 64'd5, 8'hFF, 1'b1, 1'b0);
        chk("t4a_addr_const", 64'(mem_addr), 64'd1023);
        step("t4b", 1'b1, 6, 0, 3, longint'(BASE) + 64'h2000, 64'd6, 8'hFF, 1'b1, 1'b0);
        chk("t4b_range_const", 64'(err_range), 64'd1);
        step("t4c", 1'b1, 7, 0, 3, longint'(BASE) - 8, 64'd7, 8'hFF, 1'b1, 1'b0);

        // 5: oversized beats are dropped, but they still count toward the burst length.
        for (int i = 0; i < 3; i++)
            step("t5", 1'b1, 11, 2, 4, longint'(BASE) + 16 * i, 64'd8, 8'hFF, i == 2, 1'b0);
        step("t5_head", 1'b1, 12, 0, 3, longint'(BASE) + 8, 64'd9, 8'hFF, 1'b1, 1'b0);

        // 6: back-to-back bursts with a clear mid-burst, then a reset mid-burst.
        for (int i = 0; i < 3; i++)
            step("t6a", 1'b1, 1, 2, 3, longint'(BASE) + 8 * i, 64'(i), 8'hF0, i == 2, i == 1);
        step("t6b", 1'b1, 13, 3, 3, longint'(BASE) + 256, 64'd10, 8'hFF, 1'b0, 1'b0);
        step("t6b", 1'b1, 13, 3, 3, longint'(BASE) + 264, 64'd11, 8'hFF, 1'b0, 1'b1);
        chk("t6_clr_const", 64'(stat_beats), 64'd0);
        do_reset("t6_rst");
        step("t6c", 1'b1, 14, 1, 3, longint'(BASE) + 32, 64'd12, 8'hFF, 1'b0, 1'b0);
        step("t6c", 1'b1, 14, 1, 3, longint'(BASE) + 40, 64'd13, 8'hFF, 1'b1, 1'b0);
        chk("t6_bursts_const", 64'(stat_bursts), 64'd1);

        // Random bursts.
        g_busy = 1'b0;
        for (int n = 0; n < 600; n++) begin
            longint a;
            int     r;
            bit     last;
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rnd_rst");
                continue;
            end
            if ($urandom_range(0, 3) == 0) begin
                step("rnd_idle", 1'b0, 0, 0, 0, 64'd0, 64'd0, 8'h00, 1'b0,
                     $urandom_range(0, 19) == 0);
                continue;
            end
            if (!g_busy) begin
                g_busy = 1'b1;
                g_idx  = 0;
                g_len  = $urandom_range(0, 5);
                g_id   = $urandom_range(0, 15);
                g_size = ($urandom_range(0, 7) == 0) ? 4 : $urandom_range(0, 3);
                r      = $urandom_range(0, 9);
                if (r == 0)      g_start = longint'(BASE) - $urandom_range(1, 64);
                else if (r == 1) g_start = longint'(BASE) + WIN - $urandom_range(1, 48);
                else             g_start = longint'(BASE) + $urandom_range(0, 8191);
            end
            a = g_start;
            if (g_idx > 0) a = (g_start >> g_size << g_size) + longint'(g_idx << g_size);
            last = (g_idx == g_len);
            if ($urandom_range(0, 9) == 0) last = !last;
            step("rnd", 1'b1, g_id, g_len, g_size, a, {$urandom, $urandom},
                 8'($urandom), last, $urandom_range(0, 19) == 0);
            if (g_idx == g_len) g_busy = 1'b0;
            else g_idx++;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
